micro_nonce_sched: RTL and testbench
====================================

Name: micro_nonce_sched

Overview:
- Nonce-search scheduler that sequences the 8-bit micro hash core.
- Latches a 96-bit block header and an 8-bit target from the host, then repeatedly forms the 128-bit core entry {header, nonce}, pulses the core, waits for its done strobe and checks the 24-bit result against target.
- Stops at the first passing nonce, at the nonce limit, on host abort, or on core timeout.
- Sits between the host/config interface and the hash core.

Parameters:
NONCE_W, 32, nonce width in bits; entry width is 96+NONCE_W, fixed at 128.
NONCE_LIMIT, 32'hFFFF_FFFF, last nonce tried (inclusive).
TIMEOUT, 64, max cycles to wait for core done before the error state.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a search when IDLE
abort  in  1  level; returns to IDLE from any busy state
header  in  96  block header, sampled on accepted start
target  in  8  difficulty target, sampled on accepted start
core_start  out  1  one-cycle pulse to hash core
core_entry  out  128  {header_q, nonce}; byte i = core_entry[127-8i -: 8]
core_done  in  1  one-cycle strobe, core result valid
core_hash  in  24  {H0,H1,H2}, valid with core_done
busy  out  1  high in LOAD/RUN/CHECK
found  out  1  high in FOUND state
exhausted  out  1  high in EXHAUST state
timeout_err  out  1  high in ERROR state
nonce_out  out  32  nonce of passing hash, held in FOUND
hash_out  out  24  passing hash, held in FOUND

Behaviour:
- Reset (async, active-low): state=IDLE; all outputs 0; nonce, header_q, target_q, watchdog = 0.
- States and transitions:
  - IDLE: start=1 -> latch header/target, nonce=0, go LOAD. start is ignored in all other states.
  - LOAD: drive core_entry; core_start=1 for exactly this cycle; clear watchdog; -> RUN.
  - RUN: core_done=1 -> capture core_hash into hash_q, -> CHECK. Otherwise watchdog++; watchdog reaching TIMEOUT-1 with no done -> ERROR.
  - CHECK: pass iff hash_q[23:16] < target_q AND hash_q[15:8] < target_q (unsigned, strict); H2 is not checked.
    - Pass -> nonce_out=nonce, hash_out=hash_q, -> FOUND.
    - Fail and nonce==NONCE_LIMIT -> EXHAUST.
    - Fail otherwise -> nonce++, -> LOAD.
  - FOUND / EXHAUST / ERROR: sticky; start=1 restarts exactly as from IDLE (new latch, nonce=0, -> LOAD); abort -> IDLE.
- abort has priority over every transition, including a core_done in the same cycle; returning to IDLE clears found/exhausted/timeout_err.
- Outputs are registered. core_entry is stable from LOAD until leaving RUN.
- Per-nonce overhead is 3 cycles plus core latency (LOAD 1, RUN >=1, CHECK 1).
- target_q==0 can never pass; the scheduler runs to EXHAUST (no special case).
- Nonce increment never wraps: the limit check precedes the increment.
- core_done arriving outside RUN is ignored.
- Reset asserted mid-search returns to IDLE immediately; the core is not told, and a late core_done is ignored.

Decomposition:
- Package micro_hash_pkg holds:
  - state enum (IDLE, LOAD, RUN, CHECK, FOUND, EXHAUST, ERROR);
  - widths: HDR_W=96, HASH_W=24, ENTRY_W=128;
  - function hash_meets_target(hash, target).
- One natural sub-module, micro_nonce_gen: the nonce register with clear, increment and at_limit flag. The FSM, watchdog and capture registers stay in the top.

Test Plan:
1. Core model returns 24'h0A0B0C for nonce 3 and 24'hFFFFFF otherwise, target=8'h10 -> core_start pulses 4 times, found=1, nonce_out=3, hash_out=24'h0A0B0C, busy=0.
2. NONCE_LIMIT=5, core always returns 24'hFFFFFF -> exactly 6 core_start pulses, exhausted=1, found=0.
3. Boundary compare, target=8'h20: hash 24'h20_00_00 fails; 24'h1F_1F_FF passes (H2 ignored). Check nonce_out equals the nonce of the passing hash.
4. Core never asserts done, TIMEOUT=64 -> timeout_err=1 exactly 64 cycles after the core_start pulse; start then restarts with nonce 0.
5. abort asserted in the same cycle as a passing core_done -> state IDLE, found never asserted; reset pulsed low mid-RUN -> all outputs 0 asynchronously, and a later core_done is ignored.
6. header=96'h0123_4567_89AB_CDEF_0011_2233, nonce 2 -> core_entry=128'h0123_4567_89AB_CDEF_0011_2233_0000_0002; header changed mid-search does not alter core_entry.

Source files
------------

// File: rtl/micro_hash_pkg.sv
// Shared definitions for the micro hash nonce scheduler.
//   - state_e          : scheduler FSM states
//   - HDR_W/HASH_W/... : fixed field widths of the core interface
//   - hash_meets_target: pass/fail rule applied to a core result
package micro_hash_pkg;

  localparam int unsigned HDR_W   = 96;
  localparam int unsigned HASH_W  = 24;
  localparam int unsigned TGT_W   = 8;
  localparam int unsigned ENTRY_W = 128;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CHECK   = 3'd3,
    FOUND   = 3'd4,
    EXHAUST = 3'd5,
    ERROR   = 3'd6
  } state_e;

  // Only H0 and H1 are compared; H2 never influences the verdict.
  function automatic logic hash_meets_target(input logic [HASH_W-1:0] hash,
                                             input logic [TGT_W-1:0]  target);
    return (hash[23:16] < target) && (hash[15:8] < target);
  endfunction

endpackage

// File: rtl/micro_nonce_gen.sv
// Nonce counter for the scheduler.
//   i_clk/i_rst_n : clock, asynchronous active-low reset
//   i_clr         : load zero (takes priority over i_inc)
//   i_inc         : advance by one; ignored at the limit so the count never wraps
//   o_nonce       : current nonce
//   o_at_limit    : current nonce equals NONCE_LIMIT
module micro_nonce_gen #(
  parameter int unsigned        NONCE_W     = 32,
  parameter logic [NONCE_W-1:0] NONCE_LIMIT = {NONCE_W{1'b1}}
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_inc,
  output logic [NONCE_W-1:0] o_nonce,
  output logic               o_at_limit
);

  logic [NONCE_W-1:0] r_nonce;
  logic               w_at_limit;

  assign w_at_limit = (r_nonce == NONCE_LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_nonce <= '0;
    end else if (i_clr) begin
      r_nonce <= '0;
    end else if (i_inc && !w_at_limit) begin
      r_nonce <= r_nonce + 1'b1;
    end
  end

  assign o_nonce    = r_nonce;
  assign o_at_limit = w_at_limit;

endmodule

// File: rtl/micro_nonce_sched.sv
// Nonce-search scheduler driving the 8-bit micro hash core.
// Latches header/target on start, then walks nonces 0..NONCE_LIMIT: pulse the core with
// {header, nonce}, wait for done (bounded by TIMEOUT), test the result against target.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_start, i_abort      : search start pulse, abort level (abort wins over everything)
//   i_header, i_target    : search parameters, sampled on an accepted start
//   o_core_start          : one-cycle pulse to the core (LOAD cycle)
//   o_core_entry          : {header_q, nonce}, stable from LOAD until RUN is left
//   i_core_done/hash      : core result strobe and value
//   o_busy                : in LOAD/RUN/CHECK
//   o_found/o_exhausted/o_timeout_err : sticky terminal status
//   o_nonce_out/o_hash_out: winning nonce and hash
module micro_nonce_sched
  import micro_hash_pkg::*;
#(
  parameter int unsigned        NONCE_W     = 32,
  parameter logic [NONCE_W-1:0] NONCE_LIMIT = {NONCE_W{1'b1}},
  parameter int unsigned        TIMEOUT     = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [HDR_W-1:0]         i_header,
  input  logic [TGT_W-1:0]         i_target,
  output logic                     o_core_start,
  output logic [HDR_W+NONCE_W-1:0] o_core_entry,
  input  logic                     i_core_done,
  input  logic [HASH_W-1:0]        i_core_hash,
  output logic                     o_busy,
  output logic                     o_found,
  output logic                     o_exhausted,
  output logic                     o_timeout_err,
  output logic [NONCE_W-1:0]       o_nonce_out,
  output logic [HASH_W-1:0]        o_hash_out
);

  localparam int unsigned WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Last count value seen before the watchdog would tick to TIMEOUT-1.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

  state_e             r_state, w_state_d;
  logic [HDR_W-1:0]   r_header;
  logic [TGT_W-1:0]   r_target;
  logic [HASH_W-1:0]  r_hash;
  logic [WD_W-1:0]    r_wd;
  logic               r_core_start, r_busy, r_found, r_exhausted, r_timeout_err;
  logic [NONCE_W-1:0] r_nonce_out;
  logic [HASH_W-1:0]  r_hash_out;

  logic               w_accept, w_capture, w_store, w_nonce_inc, w_pass;
  logic [NONCE_W-1:0] w_nonce;
  logic               w_at_limit;

  micro_nonce_gen #(
    .NONCE_W     (NONCE_W),
    .NONCE_LIMIT (NONCE_LIMIT)
  ) u_nonce_gen (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_accept),
    .i_inc      (w_nonce_inc),
    .o_nonce    (w_nonce),
    .o_at_limit (w_at_limit)
  );

  assign w_pass = hash_meets_target(r_hash, r_target);

  always_comb begin
    w_state_d   = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_store     = 1'b0;
    w_nonce_inc = 1'b0;
    unique case (r_state)
      IDLE, FOUND, EXHAUST, ERROR: begin
        if (i_start) begin
          w_accept  = 1'b1;
          w_state_d = LOAD;
        end
      end
      LOAD: w_state_d = RUN;
      RUN: begin
        if (i_core_done) begin
          w_capture = 1'b1;
          w_state_d = CHECK;
        end else if (r_wd == WD_LAST) begin
          w_state_d = ERROR;
        end
      end
      CHECK: begin
        if (w_pass) begin
          w_store   = 1'b1;
          w_state_d = FOUND;
        end else if (w_at_limit) begin
          w_state_d = EXHAUST;
        end else begin
          w_nonce_inc = 1'b1;
          w_state_d   = LOAD;
        end
      end
      default: w_state_d = IDLE;
    endcase
    // Abort overrides any transition and any side effect decided above.
    if (i_abort) begin
      w_state_d   = IDLE;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_store     = 1'b0;
      w_nonce_inc = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_header <= '0;
      r_target <= '0;
      r_hash   <= '0;
      r_wd     <= '0;
    end else begin
      if (w_accept) begin
        r_header <= i_header;
        r_target <= i_target;
      end
      if (w_capture) begin
        r_hash <= i_core_hash;
      end
      if (r_state == LOAD) begin
        r_wd <= '0;
      end else if (r_state == RUN && !i_core_done) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_core_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_found       <= 1'b0;
      r_exhausted   <= 1'b0;
      r_timeout_err <= 1'b0;
      r_nonce_out   <= '0;
      r_hash_out    <= '0;
    end else begin
      r_core_start  <= (w_state_d == LOAD);
      r_busy        <= (w_state_d == LOAD) || (w_state_d == RUN) || (w_state_d == CHECK);
      r_found       <= (w_state_d == FOUND);
      r_exhausted   <= (w_state_d == EXHAUST);
      r_timeout_err <= (w_state_d == ERROR);
      if (w_store) begin
        r_nonce_out <= w_nonce;
        r_hash_out  <= r_hash;
      end
    end
  end

  assign o_core_start  = r_core_start;
  assign o_core_entry  = {r_header, w_nonce};
  assign o_busy        = r_busy;
  assign o_found       = r_found;
  assign o_exhausted   = r_exhausted;
  assign o_timeout_err = r_timeout_err;
  assign o_nonce_out   = r_nonce_out;
  assign o_hash_out    = r_hash_out;

endmodule

// File: tb/tb_micro_nonce_sched.sv
module tb_micro_nonce_sched;

  localparam int unsigned LIMIT = 5;
  localparam int unsigned TMO   = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [95:0]  header = '0;
  logic [7:0]   target = '0;
  logic         core_done = 1'b0;
  logic [23:0]  core_hash = '0;
  logic         core_start;
  logic [127:0] core_entry;
  logic         busy, found, exhausted, timeout_err;
  logic [31:0]  nonce_out;
  logic [23:0]  hash_out;

  micro_nonce_sched #(
    .NONCE_W     (32),
    .NONCE_LIMIT (32'(LIMIT)),
    .TIMEOUT     (TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_abort       (abort),
    .i_header      (header),
    .i_target      (target),
    .o_core_start  (core_start),
    .o_core_entry  (core_entry),
    .i_core_done   (core_done),
    .i_core_hash   (core_hash),
    .o_busy        (busy),
    .o_found       (found),
    .o_exhausted   (exhausted),
    .o_timeout_err (timeout_err),
    .o_nonce_out   (nonce_out),
    .o_hash_out    (hash_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core behaviour and expected entry stream.
  logic [23:0]  hash_tbl [0:LIMIT];
  logic [95:0]  exp_header = '0;
  int           pulse_cnt = 0;
  bit           core_silent = 1'b1;

  // Every core_start must carry the latched header and the next nonce in order.
  initial forever begin
    @(negedge clk);
    if (core_start) begin
      check_eq("entry", core_entry, {exp_header, 32'(pulse_cnt)});
      pulse_cnt++;
    end
  end

  logic [127:0] cm_seen;
  int           cm_lat;
  int           cm_idx;
  initial forever begin
    @(negedge clk);
    if (core_start && !core_silent) begin
      cm_seen = core_entry;
      cm_lat  = int'($urandom_range(1, 4));
      repeat (cm_lat) @(negedge clk);
      check_eq("entry_stable", core_entry, cm_seen);
      cm_idx    = int'(cm_seen[31:0]);
      core_hash = (cm_idx <= LIMIT) ? hash_tbl[cm_idx] : 24'hFFFFFF;
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
    end
  end

  // Reference: first nonce in 0..LIMIT whose H0 and H1 are both below target.
  task automatic ref_search(input logic [7:0] tgt, output bit fnd, output int n,
                            output logic [23:0] h, output int pulses);
    fnd = 1'b0; n = 0; h = '0; pulses = LIMIT + 1;
    for (int i = 0; i <= LIMIT; i++) begin
      if (!fnd && hash_tbl[i][23:16] < tgt && hash_tbl[i][15:8] < tgt) begin
        fnd = 1'b1; n = i; h = hash_tbl[i]; pulses = i + 1;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_abort(input string nm);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq({nm, "_abort_busy"}, 128'(busy), 128'(0));
    check_eq({nm, "_abort_flags"}, {found, exhausted, timeout_err}, 128'(0));
  endtask

  task automatic run_search(input string nm, input logic [95:0] hdr, input logic [7:0] tgt);
    bit          fnd;
    int          n, pulses, cyc;
    logic [23:0] h;
    ref_search(tgt, fnd, n, h, pulses);
    core_silent = 1'b0;
    exp_header  = hdr;
    header      = hdr;
    target      = tgt;
    pulse_cnt   = 0;
    pulse_start();
    // Host inputs wander during the search; the latched copies must be used.
    header = {$urandom, $urandom, $urandom};
    target = 8'($urandom);
    cyc = 0;
    while (!(found || exhausted || timeout_err) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({nm, "_done_in_time"}, 128'(cyc < 2000), 128'(1));
    check_eq({nm, "_found"}, 128'(found), 128'(fnd));
    check_eq({nm, "_exhausted"}, 128'(exhausted), 128'(!fnd));
    check_eq({nm, "_tmo"}, 128'(timeout_err), 128'(0));
    check_eq({nm, "_busy"}, 128'(busy), 128'(0));
    check_eq({nm, "_pulses"}, 128'(pulse_cnt), 128'(pulses));
    if (fnd) begin
      check_eq({nm, "_nonce_out"}, 128'(nonce_out), 128'(n));
      check_eq({nm, "_hash_out"}, 128'(hash_out), 128'(h));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    for (int i = 0; i <= LIMIT; i++) hash_tbl[i] = 24'hFFFFFF;

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_flags", {core_start, busy, found, exhausted, timeout_err}, 128'(0));
    check_eq("rst_entry", core_entry, 128'(0));
    check_eq("rst_outs", {nonce_out, hash_out}, 128'(0));
    rst_n = 1'b1;

    // Found at nonce 3
    hash_tbl[3] = 24'h0A0B0C;
    run_search("t1", 96'hDEAD_BEEF_0000_1111_2222_3333, 8'h10);
    repeat (3) @(negedge clk);
    check_eq("t1_sticky", 128'(found), 128'(1));
    do_abort("t1");

    // Never passes: limit reached after LIMIT+1 nonces
    for (int i = 0; i <= LIMIT; i++) hash_tbl[i] = 24'hFFFFFF;
    run_search("t2", 96'h1, 8'h10);
    do_abort("t2");

    // Boundary compares: equal H0 fails, equal H1 fails, H2 ignored
    hash_tbl[0] = 24'h200000;
    hash_tbl[1] = 24'h1F2000;
    hash_tbl[2] = 24'h1F1FFF;
    run_search("t3", 96'hA5A5_A5A5_5A5A_5A5A_0F0F_F0F0, 8'h20);
    // Zero target never passes; restart straight from FOUND
    hash_tbl[0] = 24'h000000;
    run_search("t3z", 96'h77, 8'h00);
    do_abort("t3");

    // Header example with the pass at nonce 2
    for (int i = 0; i <= LIMIT; i++) hash_tbl[i] = 24'hFFFFFF;
    hash_tbl[2] = 24'h050505;
    run_search("t6", 96'h0123_4567_89AB_CDEF_0011_2233, 8'h10);
    do_abort("t6");

    // Silent core -> timeout 64 cycles after core_start
    core_silent = 1'b1;
    exp_header  = 96'hCAFE;
    header      = 96'hCAFE;
    pulse_cnt   = 0;
    pulse_start();
    check_eq("t4_cs", 128'(core_start), 128'(1));
    cyc = 0;
    while (!timeout_err && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t4_latency", 128'(cyc), 128'(TMO));
    check_eq("t4_busy", 128'(busy), 128'(0));
    // Restart from ERROR begins again at nonce 0
    hash_tbl[0] = 24'h010203;
    run_search("t4r", 96'hBEEF, 8'h10);
    do_abort("t4r");

    // Abort in the same cycle as a passing done
    core_silent = 1'b1;
    exp_header  = 96'h5;
    header      = 96'h5;
    target      = 8'h10;
    pulse_cnt   = 0;
    pulse_start();
    @(negedge clk);
    core_hash = 24'h000000;
    core_done = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    abort     = 1'b0;
    check_eq("t5_abort_found", 128'(found), 128'(0));
    check_eq("t5_abort_busy", 128'(busy), 128'(0));
    repeat (4) @(negedge clk);
    check_eq("t5_abort_quiet", {found, busy, 32'(pulse_cnt)}, 128'(1));

    // Reset mid-RUN, then a late done
    exp_header = 96'h0F0F_0F0F;
    header     = 96'h0F0F_0F0F;
    pulse_cnt  = 0;
    pulse_start();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_busy", 128'(busy), 128'(0));
    check_eq("t5_rst_entry", core_entry, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    core_hash = 24'h000000;
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t5_late_done", {found, busy, core_start}, 128'(0));

    // Reset while FOUND clears held results
    for (int i = 0; i <= LIMIT; i++) hash_tbl[i] = 24'hFFFFFF;
    hash_tbl[3] = 24'h0A0B0C;
    run_search("t5f", 96'h99, 8'h10);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t5f_rst", {found, nonce_out, hash_out}, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized searches, alternating abort and direct restart
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i <= LIMIT; i++) hash_tbl[i] = 24'($urandom);
      run_search($sformatf("rnd%0d", it), {$urandom, $urandom, $urandom},
                 8'($urandom_range(0, 255)));
      if (it % 2 == 1) do_abort($sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
